// File: rtl/qed_check_if.sv
// Handshake bundle between the SQED harness and qed_check_controller.
// The master side drives start/retire events and the slave side (the controller) returns the sequencing status.
interface qed_check_if #(
    parameter int CNT_W = 6
);
    logic             sif_commit;
    logic             exec_dup;
    logic             retire_valid;
    logic             retire_is_dup;
    logic             sif_commit_pulsed;
    logic             issue_dup;
    logic [CNT_W-1:0] orig_count;
    logic [CNT_W-1:0] dup_count;
    logic             qed_check_valid;
    logic             overflow;
    logic             err;

    modport master (
        output sif_commit, exec_dup, retire_valid, retire_is_dup,
        input  sif_commit_pulsed, issue_dup, orig_count, dup_count,
               qed_check_valid, overflow, err
    );

    modport slave (
        input  sif_commit, exec_dup, retire_valid, retire_is_dup,
        output sif_commit_pulsed, issue_dup, orig_count, dup_count,
               qed_check_valid, overflow, err
    );
endinterface

// File: rtl/qed_check_controller.sv
// SQED sequencing controller: start-pulse detection, original/duplicate retire counting, check trigger.
// Define QED_ERR_CHECK_EN to compile in out-of-phase retire detection and the sticky err flag.
module qed_check_controller #(
    parameter int CNT_W = 6
) (
    input logic      clk,
    input logic      rst,
    qed_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ORIG, DUP, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             sif_prev;
    logic             pulsed;
    logic             issue;
    logic             valid;
    logic             overflow;
    logic [CNT_W-1:0] orig;
    logic [CNT_W-1:0] dup;
    logic [CNT_W-1:0] dup_inc;
    logic             orig_ret;
    logic             dup_ret;
`ifdef QED_ERR_CHECK_EN
    logic             err;
`endif

    assign orig_ret = bus.retire_valid & ~bus.retire_is_dup;
    assign dup_ret  = bus.retire_valid &  bus.retire_is_dup;
    assign dup_inc  = dup + 1'b1;

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sif_prev <= 1'b0;
            pulsed   <= 1'b0;
            issue    <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            orig     <= '0;
            dup      <= '0;
`ifdef QED_ERR_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            sif_prev <= bus.sif_commit;
            pulsed   <= bus.sif_commit & ~sif_prev;

            if (state == IDLE) begin
                orig  <= '0;
                dup   <= '0;
                issue <= 1'b0;
                valid <= 1'b0;
                if (pulsed) state <= ORIG;
            end else if (!bus.sif_commit) begin
                // Dropping the start flag aborts from any active phase; retires that cycle are ignored.
                state <= IDLE;
                orig  <= '0;
                dup   <= '0;
                issue <= 1'b0;
                valid <= 1'b0;
            end else begin
                unique case (state)
                    ORIG: begin
                        if (orig_ret) begin
                            if (orig == CNT_MAX) overflow <= 1'b1;
                            else                 orig     <= orig + 1'b1;
                        end
`ifdef QED_ERR_CHECK_EN
                        if (dup_ret) err <= 1'b1;
`endif
                        if (bus.exec_dup && orig != '0) begin
                            state <= DUP;
                            issue <= 1'b1;
                        end
                    end
                    DUP: begin
                        if (dup_ret) begin
                            if (dup == CNT_MAX) begin
                                overflow <= 1'b1;
                            end else begin
                                dup <= dup_inc;
                                // A saturated run can never be trusted to match, so CHECK is withheld.
                                if (dup_inc == orig && !overflow) begin
                                    state <= CHECK;
                                    valid <= 1'b1;
                                end
                            end
                        end
`ifdef QED_ERR_CHECK_EN
                        if (orig_ret) err <= 1'b1;
`endif
                    end
                    CHECK: begin
`ifdef QED_ERR_CHECK_EN
                        if (bus.retire_valid) err <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sif_commit_pulsed = pulsed;
    assign bus.issue_dup         = issue;
    assign bus.qed_check_valid   = valid;
    assign bus.orig_count        = orig;
    assign bus.dup_count         = dup;
    assign bus.overflow          = overflow;
`ifdef QED_ERR_CHECK_EN
    assign bus.err               = err;
`else
    assign bus.err               = 1'b0;
`endif
endmodule

// File: tb/tb_qed_check_controller.sv
// Self-checking bench for qed_check_controller: directed scenarios plus randomized traffic against a phase model.
// Honours QED_ERR_CHECK_EN the same way the design does.
module tb_qed_check_controller;
    localparam int CNT_W = 3;
    localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef QED_ERR_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef enum int {P_IDLE, P_ORIG, P_DUP, P_CHECK} phase_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qed_check_if #(.CNT_W(CNT_W)) bus ();

    qed_check_controller #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the outputs must show after the next clock edge.
    phase_t phase  = P_IDLE;
    int     m_prev = 0;
    int     m_pulse = 0;
    int     m_orig = 0;
    int     m_dup  = 0;
    int     m_ovf  = 0;
    int     m_err  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic model_step(input int r, input int s, input int e, input int v, input int d);
        phase_t nphase;
        int     norig, ndup;
        if (r != 0) begin
            phase = P_IDLE; m_prev = 0; m_pulse = 0;
            m_orig = 0; m_dup = 0; m_ovf = 0; m_err = 0;
            return;
        end
        nphase = phase;
        norig  = m_orig;
        ndup   = m_dup;
        if (phase == P_IDLE) begin
            norig = 0; ndup = 0;
            if (m_pulse != 0) nphase = P_ORIG;
        end else if (s == 0) begin
            nphase = P_IDLE; norig = 0; ndup = 0;
        end else begin
            case (phase)
                P_ORIG: begin
                    if (v != 0 && d == 0) begin
                        if (m_orig == MAXV) m_ovf = 1;
                        else norig = m_orig + 1;
                    end
                    if (v != 0 && d != 0 && ERR_EN != 0) m_err = 1;
                    if (e != 0 && m_orig != 0) nphase = P_DUP;
                end
                P_DUP: begin
                    if (v != 0 && d != 0) begin
                        if (m_dup == MAXV) m_ovf = 1;
                        else begin
                            ndup = m_dup + 1;
                            if (ndup == m_orig && m_ovf == 0) nphase = P_CHECK;
                        end
                    end
                    if (v != 0 && d == 0 && ERR_EN != 0) m_err = 1;
                end
                default: begin
                    if (v != 0 && ERR_EN != 0) m_err = 1;
                end
            endcase
        end
        m_pulse = (s != 0 && m_prev == 0) ? 1 : 0;
        m_prev  = s;
        phase   = nphase;
        m_orig  = norig;
        m_dup   = ndup;
    endtask

    task automatic compare_all();
        check("sif_commit_pulsed", int'(bus.sif_commit_pulsed), m_pulse);
        check("issue_dup", int'(bus.issue_dup), (phase == P_DUP || phase == P_CHECK) ? 1 : 0);
        check("qed_check_valid", int'(bus.qed_check_valid), (phase == P_CHECK) ? 1 : 0);
        check("orig_count", int'(bus.orig_count), m_orig);
        check("dup_count", int'(bus.dup_count), m_dup);
        check("overflow", int'(bus.overflow), m_ovf);
        check("err", int'(bus.err), m_err);
    endtask

    // Drive one cycle of inputs, advance the model, and compare on the falling edge.
    task automatic cycle(input int r, input int s, input int e, input int v, input int d);
        rst               = (r != 0);
        bus.sif_commit    = (s != 0);
        bus.exec_dup      = (e != 0);
        bus.retire_valid  = (v != 0);
        bus.retire_is_dup = (d != 0);
        model_step(r, s, e, v, d);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int sif_level;

        // Reset then idle: everything stays at zero.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("reset_orig", int'(bus.orig_count), 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        check("idle_pulse", int'(bus.sif_commit_pulsed), 0);
        check("idle_valid", int'(bus.qed_check_valid), 0);

        // Start pulse lasts exactly one cycle.
        cycle(0, 1, 0, 0, 0);
        check("pulse_high", int'(bus.sif_commit_pulsed), 1);
        cycle(0, 1, 0, 0, 0);
        check("pulse_low", int'(bus.sif_commit_pulsed), 0);

        // exec_dup with nothing retired yet is refused.
        cycle(0, 1, 1, 0, 0);
        check("exec_dup_zero", int'(bus.issue_dup), 0);

        // Normal flow: 3 originals, switch, 3 duplicates.
        repeat (3) cycle(0, 1, 0, 1, 0);
        check("orig_three", int'(bus.orig_count), 3);
        check("issue_before", int'(bus.issue_dup), 0);
        cycle(0, 1, 1, 0, 0);
        check("issue_after", int'(bus.issue_dup), 1);
        repeat (2) cycle(0, 1, 0, 1, 1);
        check("valid_early", int'(bus.qed_check_valid), 0);
        cycle(0, 1, 0, 1, 1);
        check("dup_three", int'(bus.dup_count), 3);
        check("valid_on", int'(bus.qed_check_valid), 1);
        repeat (2) cycle(0, 1, 0, 0, 0);
        check("valid_hold", int'(bus.qed_check_valid), 1);
        cycle(0, 0, 0, 0, 0);
        check("abort_valid", int'(bus.qed_check_valid), 0);
        check("abort_issue", int'(bus.issue_dup), 0);
        check("abort_orig", int'(bus.orig_count), 0);

        // Saturation: 8 originals on a 3-bit counter.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (8) cycle(0, 1, 0, 1, 0);
        check("sat_orig", int'(bus.orig_count), 7);
        check("sat_ovf", int'(bus.overflow), 1);
        cycle(0, 1, 1, 0, 0);
        repeat (7) cycle(0, 1, 0, 1, 1);
        check("sat_dup", int'(bus.dup_count), 7);
        check("sat_no_valid", int'(bus.qed_check_valid), 0);
        cycle(0, 0, 0, 0, 0);
        check("ovf_sticky", int'(bus.overflow), 1);
        cycle(1, 0, 0, 0, 0);
        check("ovf_cleared", int'(bus.overflow), 0);

        // Out-of-phase duplicate retire while in ORIG.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 1);
        check("oop_err", int'(bus.err), ERR_EN);
        check("oop_dup", int'(bus.dup_count), 0);
        cycle(0, 0, 0, 0, 0);
        check("err_sticky", int'(bus.err), ERR_EN);
        cycle(1, 0, 0, 0, 0);
        check("err_cleared", int'(bus.err), 0);

        // Randomized traffic against the model.
        sif_level = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) sif_level = 1 - sif_level;
            cycle(($urandom_range(0, 299) == 0) ? 1 : 0,
                  sif_level,
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
